// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with frame-based debounce and one-cycle key_valid pulse.
// Optional feature: define KEYPAD_NUMBER_EN to shift accepted digits into a 16-bit number.
module keypad_scanner #(
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        pressed,
  output logic [15:0] number
);

  localparam logic [2:0] StDrive0 = 3'd0;
  localparam logic [2:0] StDrive1 = 3'd1;
  localparam logic [2:0] StDrive2 = 3'd2;
  localparam logic [2:0] StDrive3 = 3'd3;
  localparam logic [2:0] StEval   = 3'd4;

  localparam logic [1:0] ClsNone   = 2'd0;
  localparam logic [1:0] ClsSingle = 2'd1;
  localparam logic [1:0] ClsMulti  = 2'd2;

  localparam logic [15:0] SlotLast  = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  StableMax = 4'(DEBOUNCE_SCANS);

  logic [3:0]  col_meta_q, col_sync_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] slot_q, slot_d;
  logic [15:0] snap_q;
  logic [3:0]  row_q, row_d;
  logic [5:0]  last_cls_q, cls;
  logic [3:0]  stable_q, stable_d;
  logic [3:0]  key_code_q;
  logic        key_valid_q, pressed_q;
  logic [4:0]  zero_cnt;
  logic [3:0]  zero_idx;
  logic        is_eval, slot_done, reached, accept, rel_ok;

  assign is_eval   = (state_q == StEval);
  assign slot_done = (slot_q == SlotLast);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (is_eval) begin
      state_d = StDrive0;
      slot_d  = '0;
    end else if (slot_done) begin
      slot_d  = '0;
      state_d = (state_q == StDrive3) ? StEval : state_q + 3'd1;
    end else begin
      slot_d = slot_q + 16'd1;
    end
  end

  // Row is registered from the next state so it changes on the same edge as the FSM.
  always_comb begin
    case (state_d)
      StDrive0: row_d = 4'b1110;
      StDrive1: row_d = 4'b1101;
      StDrive2: row_d = 4'b1011;
      StDrive3: row_d = 4'b0111;
      default:  row_d = 4'b1111;
    endcase
  end

  // Snapshot bit index equals the key code 4*r + c.
  always_comb begin
    zero_cnt = '0;
    zero_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (!snap_q[i]) begin
        zero_cnt = zero_cnt + 5'd1;
        zero_idx = 4'(i);
      end
    end
    if (zero_cnt == 5'd0)      cls = {ClsNone, 4'h0};
    else if (zero_cnt == 5'd1) cls = {ClsSingle, zero_idx};
    else                       cls = {ClsMulti, 4'h0};
  end

  always_comb begin
    if (cls == last_cls_q) begin
      stable_d = (stable_q >= StableMax) ? StableMax : stable_q + 4'd1;
    end else begin
      stable_d = 4'd1;
    end
    reached = (stable_d == StableMax);
    accept  = is_eval && (cls[5:4] == ClsSingle) && reached && !pressed_q;
    rel_ok  = is_eval && (cls[5:4] == ClsNone) && reached && pressed_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta_q  <= 4'hF;
      col_sync_q  <= 4'hF;
      state_q     <= StDrive0;
      slot_q      <= '0;
      row_q       <= 4'hF;
      snap_q      <= 16'hFFFF;
      last_cls_q  <= {ClsNone, 4'h0};
      stable_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      pressed_q   <= 1'b0;
    end else begin
      col_meta_q  <= col;
      col_sync_q  <= col_meta_q;
      state_q     <= state_d;
      slot_q      <= slot_d;
      row_q       <= row_d;
      key_valid_q <= accept;
      if (!is_eval && slot_done) snap_q[{state_q[1:0], 2'b00} +: 4] <= col_sync_q;
      if (is_eval) begin
        last_cls_q <= cls;
        stable_q   <= stable_d;
      end
      if (accept) begin
        key_code_q <= cls[3:0];
        pressed_q  <= 1'b1;
      end else if (rel_ok) begin
        pressed_q <= 1'b0;
      end
    end
  end

`ifdef KEYPAD_NUMBER_EN
  logic [15:0] number_q;

  always_ff @(posedge clk) begin
    if (reset)       number_q <= '0;
    else if (accept) number_q <= {number_q[11:0], cls[3:0]};
  end

  assign number = number_q;
`else
  assign number = 16'h0000;
`endif

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign pressed   = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad (SETTLE_CYCLES=4, DEBOUNCE_SCANS=2).
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        pressed;
  logic [15:0] number;
  logic [15:0] keys = 16'h0000;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  keypad_scanner #(
    .SETTLE_CYCLES (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .pressed  (pressed),
    .number   (number)
  );

  always #5 clk = ~clk;

  // Key at row r, column c pulls col[c] low while row[r] is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && keys[4*r+c]) col[c] = 1'b0;
  end

  always @(negedge clk) if (key_valid === 1'b1) pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to the next EVAL cycle (row all high).
  task automatic wait_eval();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (row !== 4'hF && n < 40);
    if (row !== 4'hF) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_eval: row %b after %0d cycles, want 1111", row, n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    keys  = 16'h0000;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic press_key(input logic [3:0] k);
    int p;
    logic [15:0] one;
    one = 16'h0001;
    p = pulses;
    wait_eval();
    keys = one << k;
    wait_eval();
    n_cmp++;
    if (pulses !== p) begin
      n_bad++;
      $display("FAIL press_early k=%h: pulses %0d want %0d", k, pulses, p);
    end
    wait_eval();
    step();
    n_cmp++;
    if (key_valid !== 1'b1 || key_code !== k || pressed !== 1'b1) begin
      n_bad++;
      $display("FAIL press_accept k=%h: valid=%b code=%h pressed=%b want 1 %h 1",
               k, key_valid, key_code, pressed, k);
    end
    step();
    n_cmp++;
    if (key_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL pulse_width k=%h: valid=%b want 0", k, key_valid);
    end
  endtask

  task automatic release_key();
    int p;
    p = pulses;
    wait_eval();
    keys = 16'h0000;
    wait_eval();
    step();
    n_cmp++;
    if (pressed !== 1'b1) begin
      n_bad++;
      $display("FAIL release_early: pressed=%b want 1", pressed);
    end
    wait_eval();
    step();
    n_cmp++;
    if (pressed !== 1'b0 || pulses !== p) begin
      n_bad++;
      $display("FAIL release: pressed=%b pulses=%0d want 0 %0d", pressed, pulses, p);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    keys  = 16'h0000;
    repeat (3) step();
    n_cmp++;
    if (row !== 4'hF || key_code !== 4'h0 || key_valid !== 1'b0 || pressed !== 1'b0 ||
        number !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_values: row=%b code=%h valid=%b pressed=%b number=%h want 1111 0 0 0 0000",
               row, key_code, key_valid, pressed, number);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (row !== 4'b1110) begin
      n_bad++;
      $display("FAIL first_row: row=%b want 1110", row);
    end
  endtask

  task automatic test_idle_scan();
    int p;
    logic [3:0] one;
    logic [3:0] exp;
    one = 4'b0001;
    p = pulses;
    wait_eval();
    for (int i = 0; i < 17; i++) begin
      step();
      exp = (i < 16) ? ~(one << (i / 4)) : 4'hF;
      n_cmp++;
      if (row !== exp) begin
        n_bad++;
        $display("FAIL idle_row cycle %0d: row=%b want %b", i, row, exp);
      end
    end
    repeat (3) wait_eval();
    n_cmp++;
    if (pulses !== p || pressed !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_quiet: pulses=%0d pressed=%b want %0d 0", pulses, pressed, p);
    end
  endtask

  task automatic test_single_key();
    press_key(4'h9);
    release_key();
  endtask

  task automatic test_bounce();
    int p;
    p = pulses;
    for (int i = 0; i < 6; i++) begin
      wait_eval();
      keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
    end
    wait_eval();
    keys = 16'h0020;
    wait_eval();
    n_cmp++;
    if (pulses !== p) begin
      n_bad++;
      $display("FAIL bounce_quiet: pulses=%0d want %0d", pulses, p);
    end
    wait_eval();
    step();
    n_cmp++;
    if (key_valid !== 1'b1 || key_code !== 4'h5) begin
      n_bad++;
      $display("FAIL bounce_accept: valid=%b code=%h want 1 5", key_valid, key_code);
    end
    step();
    release_key();
  endtask

  task automatic test_multi();
    int p;
    p = pulses;
    wait_eval();
    keys = 16'h8001;
    repeat (4) wait_eval();
    step();
    n_cmp++;
    if (pulses !== p || pressed !== 1'b0) begin
      n_bad++;
      $display("FAIL multi_quiet: pulses=%0d pressed=%b want %0d 0", pulses, pressed, p);
    end
    wait_eval();
    keys = 16'h0001;
    wait_eval();
    wait_eval();
    step();
    n_cmp++;
    if (key_valid !== 1'b1 || key_code !== 4'h0 || pulses !== p) begin
      n_bad++;
      $display("FAIL multi_drop: valid=%b code=%h pulses=%0d want 1 0 %0d",
               key_valid, key_code, pulses, p);
    end
    step();
    release_key();
  endtask

  task automatic test_reset_mid_scan();
    int p;
    p = pulses;
    wait_eval();
    keys = 16'h0080;
    wait_eval();
    step();
    step();
    step();
    reset = 1'b1;
    step();
    n_cmp++;
    if (row !== 4'hF || key_valid !== 1'b0 || pressed !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: row=%b valid=%b pressed=%b want 1111 0 0", row, key_valid, pressed);
    end
    reset = 1'b0;
    wait_eval();
    n_cmp++;
    if (pulses !== p) begin
      n_bad++;
      $display("FAIL mid_reset_early: pulses=%0d want %0d", pulses, p);
    end
    wait_eval();
    step();
    n_cmp++;
    if (key_valid !== 1'b1 || key_code !== 4'h7) begin
      n_bad++;
      $display("FAIL mid_reset_accept: valid=%b code=%h want 1 7", key_valid, key_code);
    end
    step();
    release_key();
  endtask

  task automatic test_number();
    logic [15:0] exp_num;
    do_reset();
    exp_num = 16'h0000;
    for (int k = 1; k <= 5; k++) begin
      press_key(4'(k));
`ifdef KEYPAD_NUMBER_EN
      exp_num = {exp_num[11:0], 4'(k)};
`endif
      n_cmp++;
      if (number !== exp_num) begin
        n_bad++;
        $display("FAIL number k=%0d: number=%h want %h", k, number, exp_num);
      end
      release_key();
    end
    n_cmp++;
`ifdef KEYPAD_NUMBER_EN
    if (number !== 16'h2345) begin
`else
    if (number !== 16'h0000) begin
`endif
      n_bad++;
      $display("FAIL number_final: number=%h want %h", number, exp_num);
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_key();
    test_bounce();
    test_multi();
    test_reset_mid_scan();
    test_number();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Scans a 4x4 active-low matrix keypad and debounces presses into a 4-bit hex key code, with a one-cycle valid pulse.
- Optionally shifts each accepted digit into a 16-bit number.
- Input-side counterpart of the multiplexed seven-segment display: drives one keypad row at a time the way the display drives one anode at a time.
- Its optional number output can feed the display's number input directly.

## Interface
- SETTLE_CYCLES, 1024: clock cycles each row is driven before its columns are sampled; legal range 4..65535.
- DEBOUNCE_SCANS, 4: consecutive identical full-matrix frames needed to accept a press or a release; legal range 1..15.
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- row  output  4  row drive, active-low, exactly one bit low while scanning.
- col  input  4  column sense, active-low, asynchronous to clk.
- key_code  output  4  code of the last accepted key.
- key_valid  output  1  one-cycle pulse when a new press is accepted.
- pressed  output  1  high from press acceptance until release acceptance.
- number  output  16  hex digits entered, newest in [3:0]; only meaningful with the macro.

## Operation
- col passes through a two-flop synchronizer before any use.
- Scan FSM states: DRIVE(r) for r = 0..3, then EVAL.
  - In DRIVE(r), row = ~(1 << r).
  - A slot counter runs 0..SETTLE_CYCLES-1.
  - On the edge where the counter equals SETTLE_CYCLES-1, the synchronized col is stored into snapshot[r], and the FSM moves to DRIVE(r+1), or to EVAL after r = 3.
- EVAL lasts one cycle.
  - row = 4'b1111 during EVAL.
  - After EVAL the FSM returns to DRIVE(0).
  - Frame period = 4*SETTLE_CYCLES + 1 cycles.
- Frame classification in EVAL:
  - NONE: all 16 snapshot bits are 1.
  - SINGLE(k): exactly one bit is 0, at row r and column c; k = 4*r + c.
  - MULTI: two or more bits are 0.
- Debounce:
  - Keep the last frame class and a stable counter that saturates at DEBOUNCE_SCANS.
  - If this frame's class equals the last class, increment the counter; otherwise set the counter to 1.
  - Press acceptance: class SINGLE(k), counter reaches DEBOUNCE_SCANS on this frame, and pressed = 0.
    - Same cycle: key_code <= k, pressed <= 1, key_valid <= 1.
  - Release acceptance: class NONE, counter reaches DEBOUNCE_SCANS, and pressed = 1.
    - pressed <= 0.
  - MULTI frames never accept and never release. They only break stability.
  - While pressed = 1, a stable SINGLE of a different key does nothing. A release must come first.
- key_valid is a registered pulse, high on the cycle after the EVAL edge, for exactly one cycle.

## Timing
- Reset values:
  - row = 4'b1111, key_code = 0, key_valid = 0, pressed = 0, number = 0.
  - FSM = DRIVE(0), slot counter = 0.
  - Snapshot and last class = NONE, stable counter = 0; the synchronizer flops = 4'b1111.
- The first clock edge after reset deasserts sets row = 4'b1110.
- Column-to-snapshot latency is 2 cycles (synchronizer), which is why SETTLE_CYCLES is at least 4.
- Press latency: from the first frame whose snapshot shows the key to key_valid is (DEBOUNCE_SCANS-1) frame periods plus 1 cycle.
  - With DEBOUNCE_SCANS = 1, key_valid rises the cycle after that frame's EVAL.
- Wrap-around and saturation:
  - The stable counter saturates; it never wraps.
  - The number register drops its top digit on each shift.
- Reset asserted mid-scan or mid-pulse:
  - All state returns to reset values on that edge; key_valid drops immediately.
  - No partial frame is evaluated.

## Configuration
- KEYPAD_NUMBER_EN defined:
  - On each press acceptance, number <= {number[11:0], k}, in the same cycle as key_valid is set.
  - number is registered and reset to 0.
- KEYPAD_NUMBER_EN undefined:
  - number is tied to 16'h0000 and no shift register is synthesized.
  - All other behaviour is identical.

## Test plan
All scenarios use SETTLE_CYCLES = 4 and DEBOUNCE_SCANS = 2, so the frame period is 17 cycles.
- Reset then idle, col = 4'hF throughout:
  - row cycles 1110, 1101, 1011, 0111, 1111 with slot lengths 4, 4, 4, 4, 1.
  - key_valid never asserts; pressed = 0.
- Key row 2, col 1 held (col[1] low only while row[2] low):
  - exactly one key_valid pulse, 2 frames after the first pressed frame, with key_code = 4'h9 and pressed = 1.
  - Releasing for 2 frames sets pressed = 0 with no further pulse.
- Bounce: key 4'h5 present in alternating frames for 6 frames, then steady:
  - no pulse during the alternation; one pulse with key_code = 4'h5 after 2 steady frames.
- Keys 4'h0 and 4'hF held together:
  - MULTI, so no pulse and pressed stays 0.
  - Dropping 4'hF gives a pulse with key_code = 4'h0 after 2 frames.
- Reset asserted 3 cycles into the second stable frame of key 4'h7:
  - no pulse; row = 4'b1111 on the next cycle.
  - Holding the key afterwards gives a pulse 2 full frames after reset release.
- With KEYPAD_NUMBER_EN, press and release 1, 2, 3, 4, 5 in turn: number = 16'h2345.
  - Without the macro, number = 16'h0000 throughout.
